// File: rtl/mmio_pkg.sv
// Shared constants and FSM state type for the data-memory MMIO controller.
package mmio_pkg;

  localparam logic [31:0] DEF_HALT_ADDR  = 32'hF000_0000;
  localparam logic [31:0] DEF_SIG_ADDR   = 32'hF000_0004;
  localparam logic [31:0] DEF_HALT_MAGIC = 32'hCAFE_CAFE;

  typedef enum logic [1:0] {
    MMIO_RUN     = 2'd0,
    MMIO_DRAIN   = 2'd1,
    MMIO_HALTED  = 2'd2
  } mmio_state_t;

endpackage

// File: rtl/sig_fifo.sv
// Synchronous FIFO for signature words; DEPTH must be a power of 2 so pointers wrap naturally.
module sig_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// MMIO decode between core write port and memory: signature FIFO, halt/drain/done sequencing.
// Optional DMEM_MMIO_SIGCNT_EN adds a saturating count of accepted signature pushes.
module dmem_mmio_ctrl
  import mmio_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR  = DEF_HALT_ADDR,
  parameter logic [31:0] SIG_ADDR   = DEF_SIG_ADDR,
  parameter logic [31:0] HALT_MAGIC = DEF_HALT_MAGIC,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        sysclk,
  input  logic        rst_in,
  input  logic        dmem_wr_en,
  input  logic [31:0] dmem_wr_addr,
  input  logic [31:0] dmem_wr_data,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        sig_valid,
  output logic [31:0] sig_data,
  input  logic        sig_ready,
  output logic        sig_overflow,
  output logic        done
`ifdef DMEM_MMIO_SIGCNT_EN
  ,
  output logic [31:0] sig_count
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  mmio_state_t     state_q, state_d;
  logic            running, halt_hit, sig_push, sig_pop, push_acc;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            overflow_q, overflow_d;

  assign running  = (state_q == MMIO_RUN);
  assign halt_hit = (dmem_wr_addr == HALT_ADDR) && (dmem_wr_data == HALT_MAGIC);

  // Zero-latency forward keeps the core's single-cycle write timing.
  assign mem_wr_en   = dmem_wr_en & running & ~halt_hit;
  assign mem_wr_addr = dmem_wr_addr;
  assign mem_wr_data = dmem_wr_data;

  assign sig_push  = dmem_wr_en & running & (dmem_wr_addr == SIG_ADDR);
  assign sig_valid = ~fifo_empty;
  assign sig_pop   = sig_valid & sig_ready;
  assign push_acc  = sig_push & (~fifo_full | sig_pop);
  assign done      = (state_q == MMIO_HALTED);

  sig_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_sig_fifo (
    .clk_i   (sysclk),
    .rst_i   (rst_in),
    .push_i  (push_acc),
    .data_i  (dmem_wr_data),
    .pop_i   (sig_pop),
    .data_o  (sig_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q | (sig_push & ~push_acc);
    case (state_q)
      MMIO_RUN: begin
        if (dmem_wr_en && halt_hit) state_d = MMIO_DRAIN;
      end
      MMIO_DRAIN: begin
        // Leave as the last word is popped, so done follows the final pop by one cycle.
        if (fifo_empty || (fifo_count == CntW'(1) && sig_pop)) state_d = MMIO_HALTED;
      end
      MMIO_HALTED: state_d = MMIO_HALTED;
      default:     state_d = MMIO_RUN;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= MMIO_RUN;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign sig_overflow = overflow_q;

`ifdef DMEM_MMIO_SIGCNT_EN
  logic [31:0] sig_count_q, sig_count_d;

  always_comb begin
    sig_count_d = sig_count_q;
    if (push_acc && (sig_count_q != 32'hFFFF_FFFF)) sig_count_d = sig_count_q + 32'd1;
  end

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) sig_count_q <= '0;
    else        sig_count_q <= sig_count_d;
  end

  assign sig_count = sig_count_q;
`endif

endmodule
